// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file initiator: default sizes,
// FSM state codes and the command op encoding.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 64;
    localparam int unsigned DEFAULT_DEPTH  = 16;
    localparam int unsigned DEFAULT_SELECT = 4;

    // FSM state codes
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4;

    // Value of cmd_write
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/regfile_rsp_reg.sv
// Response capture/hold register. Loads both read words on capture and
// raises rsp_valid; the data stays frozen until the host takes it.
module regfile_rsp_reg
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] rd_data1,
    input  logic [WIDTH-1:0] rd_data2,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [WIDTH-1:0] rsp_data2
);

    logic             valid_q;
    logic [WIDTH-1:0] data1_q;
    logic [WIDTH-1:0] data2_q;

    // Capture on request, drop valid on handshake, hold data otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            data1_q <= rd_data1;
            data2_q <= rd_data2;
        end else if (valid_q && rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_data1 = data1_q;
    assign rsp_data2 = data2_q;

endmodule

// File: rtl/regfile_initiator.sv
// Register-file initiator: takes host read/write commands and plays them
// onto a level-sensitive register file with registered, non-overlapping
// cs/re/we strobes. Read results return on a valid/ready channel.
// Optional feature: define RF_CLEAR_EN to sweep zeros into every entry
// after reset before the first command is accepted.
module regfile_initiator
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned SELECT = DEFAULT_SELECT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [SELECT-1:0] cmd_reg1,
    input  logic [SELECT-1:0] cmd_reg2,
    input  logic [WIDTH-1:0]  cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data1,
    output logic [WIDTH-1:0]  rsp_data2,
    output logic              busy,
    output logic              rf_cs,
    output logic              rf_re,
    output logic              rf_we,
    output logic [SELECT-1:0] rf_read_reg1,
    output logic [SELECT-1:0] rf_read_reg2,
    output logic [SELECT-1:0] rf_write_register,
    output logic [WIDTH-1:0]  rf_write_data,
    input  logic [WIDTH-1:0]  rf_read_data1,
    input  logic [WIDTH-1:0]  rf_read_data2
);

    if (DEPTH != (32'd1 << SELECT)) begin : g_depth_check
        $error("regfile_initiator: DEPTH must equal 2**SELECT");
    end

`ifdef RF_CLEAR_EN
    localparam logic [2:0] RESET_STATE = CLEAR;
`else
    localparam logic [2:0] RESET_STATE = IDLE;
`endif

    logic [2:0]        state_q, state_d;
    logic              cs_q, cs_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [SELECT-1:0] rreg1_q, rreg1_d;
    logic [SELECT-1:0] rreg2_q, rreg2_d;
    logic [SELECT-1:0] wreg_q, wreg_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              capture;
    logic              accept;
    logic              rsp_done;
`ifdef RF_CLEAR_EN
    logic [SELECT-1:0] clr_cnt_q, clr_cnt_d;
`endif

    assign accept   = cmd_valid && ready_q;
    assign rsp_done = rsp_valid && rsp_ready;

    // Next-state and next-output decode; every output is a flop loaded from here
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        re_d    = re_q;
        we_d    = we_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        rreg1_d = rreg1_q;
        rreg2_d = rreg2_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        capture = 1'b0;
`ifdef RF_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                cs_d    = 1'b0;
                re_d    = 1'b0;
                we_d    = 1'b0;
                if (accept) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    if (cmd_write == OP_WRITE) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        wreg_d  = cmd_reg1;
                        wdata_d = cmd_wdata;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                        rreg1_d = cmd_reg1;
                        rreg2_d = cmd_reg2;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                we_d    = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            READ: begin
                // File output is valid for the whole READ cycle; sample it at the closing edge
                state_d = RESP;
                cs_d    = 1'b0;
                re_d    = 1'b0;
                capture = 1'b1;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
`ifdef RF_CLEAR_EN
            CLEAR: begin
                // Leave once the write to the last entry has been on the pins for its cycle
                if (cs_q && (wreg_q == SELECT'(DEPTH - 1))) begin
                    state_d = IDLE;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cs_d      = 1'b1;
                    we_d      = 1'b1;
                    re_d      = 1'b0;
                    wreg_d    = clr_cnt_q;
                    wdata_d   = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                re_d    = 1'b0;
                we_d    = 1'b0;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output flops; reset clears strobes asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cs_q    <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rreg1_q <= '0;
            rreg2_q <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            re_q    <= re_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rreg1_q <= rreg1_d;
            rreg2_q <= rreg2_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef RF_CLEAR_EN
    // Sweep counter; reset restarts the clear from entry 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    regfile_rsp_reg #(
        .WIDTH (WIDTH)
    ) u_rsp_reg (
        .clock     (clock),
        .reset     (reset),
        .capture   (capture),
        .rd_data1  (rf_read_data1),
        .rd_data2  (rf_read_data2),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_data1 (rsp_data1),
        .rsp_data2 (rsp_data2)
    );

    assign cmd_ready         = ready_q;
    assign busy              = busy_q;
    assign rf_cs             = cs_q;
    assign rf_re             = re_q;
    assign rf_we             = we_q;
    assign rf_read_reg1      = rreg1_q;
    assign rf_read_reg2      = rreg2_q;
    assign rf_write_register = wreg_q;
    assign rf_write_data     = wdata_q;

endmodule

// File: tb/tb_regfile_initiator.sv
// Bench for regfile_initiator: a behavioural register file driven by the
// DUT strobes, plus an independent command-level model of what each entry
// should hold. Reads are checked against that model.
module tb_regfile_initiator;

    localparam int WIDTH  = 64;
    localparam int SELECT = 4;
    localparam int DEPTH  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [SELECT-1:0] cmd_reg1;
    logic [SELECT-1:0] cmd_reg2;
    logic [WIDTH-1:0]  cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data1;
    logic [WIDTH-1:0]  rsp_data2;
    logic              busy;
    logic              rf_cs;
    logic              rf_re;
    logic              rf_we;
    logic [SELECT-1:0] rf_read_reg1;
    logic [SELECT-1:0] rf_read_reg2;
    logic [SELECT-1:0] rf_write_register;
    logic [WIDTH-1:0]  rf_write_data;
    logic [WIDTH-1:0]  rf_read_data1;
    logic [WIDTH-1:0]  rf_read_data2;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] file_mem [DEPTH];  // register file attached to the pins
    logic [WIDTH-1:0] ref_mem  [DEPTH];  // expected contents, from commands only

    regfile_initiator dut (
        .clock             (clock),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_reg1          (cmd_reg1),
        .cmd_reg2          (cmd_reg2),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data1         (rsp_data1),
        .rsp_data2         (rsp_data2),
        .busy              (busy),
        .rf_cs             (rf_cs),
        .rf_re             (rf_re),
        .rf_we             (rf_we),
        .rf_read_reg1      (rf_read_reg1),
        .rf_read_reg2      (rf_read_reg2),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .rf_read_data1     (rf_read_data1),
        .rf_read_data2     (rf_read_data2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rf_cs && rf_we) file_mem[rf_write_register] <= rf_write_data;
    end
    assign rf_read_data1 = file_mem[rf_read_reg1];
    assign rf_read_data2 = file_mem[rf_read_reg2];

    // Strobes must never overlap
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            if (rf_re === 1'b1 && rf_we === 1'b1) begin
                errors++;
                $display("FAIL strobe_excl: re=%b we=%b, required not both 1", rf_re, rf_we);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
    endtask

    task automatic do_write(input logic [SELECT-1:0] r, input logic [WIDTH-1:0] d);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_reg1  = r;
        cmd_reg2  = SELECT'($urandom);
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = {$urandom, $urandom};
        ref_mem[r] = d;
        checks += 4;
        if ({rf_cs, rf_we, rf_re} !== 3'b110) begin
            errors++;
            $display("FAIL wr_strobe: cs/we/re=%b, required 110", {rf_cs, rf_we, rf_re});
        end
        if (rf_write_register !== r || rf_write_data !== d) begin
            errors++;
            $display("FAIL wr_sel: reg=%0d data=%h, required reg=%0d data=%h",
                     rf_write_register, rf_write_data, r, d);
        end
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_norsp: rsp_valid=%b, required 0", rsp_valid);
        end
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy: cmd_ready=%b busy=%b, required 0/1", cmd_ready, busy);
        end
        tick();
        checks += 2;
        if ({rf_cs, rf_we, rf_re} !== 3'b000) begin
            errors++;
            $display("FAIL wr_pulse: cs/we/re=%b one cycle later, required 000",
                     {rf_cs, rf_we, rf_re});
        end
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic do_read(input logic [SELECT-1:0] r1, input logic [SELECT-1:0] r2,
                           input int stall);
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        e1 = ref_mem[r1];
        e2 = ref_mem[r2];
        wait_ready();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_reg1  = r1;
        cmd_reg2  = r2;
        tick();
        cmd_valid = 1'b0;
        cmd_reg1  = SELECT'($urandom);
        cmd_reg2  = SELECT'($urandom);
        checks += 3;
        if ({rf_cs, rf_re, rf_we} !== 3'b110) begin
            errors++;
            $display("FAIL rd_strobe: cs/re/we=%b, required 110", {rf_cs, rf_re, rf_we});
        end
        if (rf_read_reg1 !== r1 || rf_read_reg2 !== r2) begin
            errors++;
            $display("FAIL rd_sel: sel=%0d/%0d, required %0d/%0d", rf_read_reg1, rf_read_reg2, r1, r2);
        end
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_early: rsp_valid=%b one cycle after accept, required 0", rsp_valid);
        end
        tick();
        checks += 3;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_latency: rsp_valid=%b two cycles after accept, required 1", rsp_valid);
        end
        if (rsp_data1 !== e1 || rsp_data2 !== e2) begin
            errors++;
            $display("FAIL rd_data: got %h/%h, required %h/%h", rsp_data1, rsp_data2, e1, e2);
        end
        if (rf_cs !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_resp_state: cs=%b cmd_ready=%b busy=%b, required 0/0/1",
                     rf_cs, cmd_ready, busy);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data1 !== e1 || rsp_data2 !== e2 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL rd_hold: cycle %0d valid=%b data=%h/%h cmd_ready=%b, required 1 %h/%h 0",
                         i, rsp_valid, rsp_data1, rsp_data2, cmd_ready, e1, e2);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: valid=%b cmd_ready=%b busy=%b, required 0/1/0",
                     rsp_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_reg1  = '0;
        cmd_reg2  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) tick();
        checks += 3;
        if ({cmd_ready, busy, rsp_valid, rf_cs, rf_re, rf_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready/busy/valid/cs/re/we=%b, required 000000",
                     {cmd_ready, busy, rsp_valid, rf_cs, rf_re, rf_we});
        end
        if ({rf_read_reg1, rf_read_reg2, rf_write_register} !== '0 || rf_write_data !== '0) begin
            errors++;
            $display("FAIL reset_sel: sel=%0d/%0d/%0d wdata=%h, required all 0",
                     rf_read_reg1, rf_read_reg2, rf_write_register, rf_write_data);
        end
        if (rsp_data1 !== '0 || rsp_data2 !== '0) begin
            errors++;
            $display("FAIL reset_rsp: data=%h/%h, required 0", rsp_data1, rsp_data2);
        end
        reset = 1'b0;
`ifdef RF_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++;
            if ({rf_cs, rf_we, rf_re} !== 3'b110 || rf_write_register !== SELECT'(i) ||
                rf_write_data !== '0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL clear_%0d: cs/we/re=%b reg=%0d data=%h ready=%b busy=%b, required 110 %0d 0 0 1",
                         i, {rf_cs, rf_we, rf_re}, rf_write_register, rf_write_data, cmd_ready, busy, i);
            end
            ref_mem[i] = '0;
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || rf_cs !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: ready=%b cs=%b busy=%b, required 1/0/0", cmd_ready, rf_cs, busy);
        end
        do_read(SELECT'(7), SELECT'(7), 0);
`else
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rf_cs !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b cs=%b, required 1/0/0", cmd_ready, busy, rf_cs);
        end
`endif
    endtask

    task automatic test_write_read();
        do_write(SELECT'(3), 64'hDEAD_BEEF_0000_0001);
        do_read(SELECT'(3), SELECT'(3), 0);
    endtask

    task automatic test_backpressure();
        do_write(SELECT'(9), 64'h0123_4567_89AB_CDEF);
        do_read(SELECT'(9), SELECT'(3), 5);
    endtask

    task automatic test_reset_mid_read();
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_reg1  = SELECT'(3);
        cmd_reg2  = SELECT'(9);
        tick();
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (rf_cs !== 1'b0 || rf_re !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: cs=%b re=%b right after reset, required 0/0", rf_cs, rf_re);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_norsp: rsp_valid=%b cycle %0d after release, required 0", rsp_valid, i);
            end
        end
`ifdef RF_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
        wait_ready();
    endtask

    task automatic test_random();
        for (int i = 0; i < DEPTH; i++) do_write(SELECT'(i), {$urandom, $urandom});
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(SELECT'($urandom), {$urandom, $urandom});
            else
                do_read(SELECT'($urandom), SELECT'($urandom), int'($urandom_range(2, 0)));
        end
    endtask

    task automatic test_back_to_back();
        do_write(SELECT'(0), 64'hFFFF_0000_FFFF_0000);
        do_write(SELECT'(15), 64'h0000_FFFF_0000_FFFF);
        do_read(SELECT'(0), SELECT'(15), 0);
        do_read(SELECT'(15), SELECT'(0), 0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_reset_mid_read();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
